jr_redirect_ctrl: RTL and testbench

Pipeline PC-redirect controller for the 5-stage MIPS core. Sits between ID-stage decode and the PC/IF-ID/ID-EX pipeline registers. Sequences JR, J/JAL and taken-branch redirects, stalls JR until its `rs` operand is safe to read in ID, and issues the matching flushes and bubbles. Keeps saturating JR and stall counters for performance debug.

---
 rtl/jr_redirect_ctrl_pkg.sv | 32 +++
 rtl/jr_redirect_ctrl_if.sv | 37 +++
 rtl/jr_redirect_ctrl_rs_hazard_check.sv | 17 +
 rtl/jr_redirect_ctrl.sv | 120 ++++++++++++
 tb/tb_jr_redirect_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jr_redirect_ctrl_pkg.sv
// Shared types and helpers for the PC-redirect controller.
package jr_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    PC4    = 2'b00,
    BRANCH = 2'b01,
    JUMP   = 2'b10,
    JR     = 2'b11
  } pc_sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RS = 1'b1
  } redir_state_e;

  localparam logic [1:0]  ALU_OP_RTYPE = 2'b10;
  localparam logic [5:0]  FN_JR        = 6'b001000;
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  // JR decoder: valid R-type with the JR function code.
  function automatic logic jr_control(input logic       valid,
                                      input logic [1:0] alu_op,
                                      input logic [5:0] fn);
    return valid && (alu_op == ALU_OP_RTYPE) && (fn == FN_JR);
  endfunction

  // Saturating increment for the debug counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/jr_redirect_ctrl_if.sv
// Pipeline-side bundle: ID/EX/MEM observation inputs and redirect/stall outputs.
interface jr_redirect_ctrl_if;
  logic        id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_fn;
  logic        id_jump;
  logic [4:0]  id_rs;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic        ex_branch_taken;
  logic [1:0]  pc_sel;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        busy;
  logic [15:0] jr_count;
  logic [15:0] jr_stall_count;

  // Pipeline side: presents decode/hazard state, consumes control.
  modport master (
    output id_valid, id_alu_op, id_fn, id_jump, id_rs,
           ex_reg_write, ex_rd, mem_mem_read, mem_rd, ex_branch_taken,
    input  pc_sel, pc_write, ifid_write, ifid_flush, idex_flush,
           busy, jr_count, jr_stall_count
  );

  // Controller side.
  modport slave (
    input  id_valid, id_alu_op, id_fn, id_jump, id_rs,
           ex_reg_write, ex_rd, mem_mem_read, mem_rd, ex_branch_taken,
    output pc_sel, pc_write, ifid_write, ifid_flush, idex_flush,
           busy, jr_count, jr_stall_count
  );
endinterface

// File: rtl/jr_redirect_ctrl_rs_hazard_check.sv
// Flags a RAW hazard on the JR source register. Without forwarding into ID,
// rs is unsafe while an EX writer or a MEM load still targets it.
// Register 0 is hardwired and never hazards.
module rs_hazard_check (
  input  logic [4:0] id_rs_i,
  input  logic       ex_reg_write_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_mem_read_i,
  input  logic [4:0] mem_rd_i,
  output logic       hazard_o
);
  logic ex_hit, mem_hit;

  assign ex_hit   = ex_reg_write_i && (ex_rd_i == id_rs_i);
  assign mem_hit  = mem_mem_read_i && (mem_rd_i == id_rs_i);
  assign hazard_o = (id_rs_i != 5'd0) && (ex_hit || mem_hit);
endmodule

// File: rtl/jr_redirect_ctrl.sv
// PC-redirect controller: sequences branch, JR and J/JAL redirects, stalls
// JR until rs is safe to read in ID, and keeps saturating debug counters.
module jr_redirect_ctrl
  import jr_redirect_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  jr_redirect_ctrl_if.slave  bus
);

  redir_state_e state_q, state_d;
  logic [15:0]  jr_cnt_q, jr_cnt_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;

  pc_sel_e pc_sel_w;
  logic    pc_write_w, ifid_write_w, ifid_flush_w, idex_flush_w;
  logic    is_jr, hazard;

  assign is_jr = jr_control(bus.id_valid, bus.id_alu_op, bus.id_fn);

  rs_hazard_check u_hz (
    .id_rs_i        (bus.id_rs),
    .ex_reg_write_i (bus.ex_reg_write),
    .ex_rd_i        (bus.ex_rd),
    .mem_mem_read_i (bus.mem_mem_read),
    .mem_rd_i       (bus.mem_rd),
    .hazard_o       (hazard)
  );

  // State and counter registers; reset abandons any pending JR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      jr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      jr_cnt_q    <= jr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state, counter updates and combinational redirect/stall controls.
  // Priority: taken branch > JR > J/JAL > sequential fetch.
  always_comb begin
    state_d      = state_q;
    jr_cnt_d     = jr_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    pc_sel_w     = PC4;
    pc_write_w   = 1'b1;
    ifid_write_w = 1'b1;
    ifid_flush_w = 1'b0;
    idex_flush_w = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ex_branch_taken) begin
          pc_sel_w     = BRANCH;
          ifid_flush_w = 1'b1;
          idex_flush_w = 1'b1;
        end else if (is_jr && hazard) begin
          pc_write_w   = 1'b0;
          ifid_write_w = 1'b0;
          idex_flush_w = 1'b1;
          stall_cnt_d  = sat_inc(stall_cnt_q);
          state_d      = WAIT_RS;
        end else if (is_jr) begin
          pc_sel_w     = JR;
          ifid_flush_w = 1'b1;
          jr_cnt_d     = sat_inc(jr_cnt_q);
        end else if (bus.id_jump) begin
          pc_sel_w     = JUMP;
          ifid_flush_w = 1'b1;
        end
      end
      WAIT_RS: begin
        if (bus.ex_branch_taken) begin
          // Older branch squashes the stalled JR; it is not counted.
          pc_sel_w     = BRANCH;
          ifid_flush_w = 1'b1;
          idex_flush_w = 1'b1;
          state_d      = IDLE;
        end else if (is_jr && hazard) begin
          pc_write_w   = 1'b0;
          ifid_write_w = 1'b0;
          idex_flush_w = 1'b1;
          stall_cnt_d  = sat_inc(stall_cnt_q);
        end else if (is_jr) begin
          pc_sel_w     = JR;
          ifid_flush_w = 1'b1;
          jr_cnt_d     = sat_inc(jr_cnt_q);
          state_d      = IDLE;
        end else begin
          // The held instruction vanished: recover with plain fetch.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold the front end frozen and flushed while reset is asserted.
    if (!rst_n) begin
      pc_sel_w     = PC4;
      pc_write_w   = 1'b0;
      ifid_write_w = 1'b0;
      ifid_flush_w = 1'b1;
      idex_flush_w = 1'b1;
    end
  end

  assign bus.pc_sel         = pc_sel_w;
  assign bus.pc_write       = pc_write_w;
  assign bus.ifid_write     = ifid_write_w;
  assign bus.ifid_flush     = ifid_flush_w;
  assign bus.idex_flush     = idex_flush_w;
  assign bus.busy           = rst_n && (state_q == WAIT_RS);
  assign bus.jr_count       = jr_cnt_q;
  assign bus.jr_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_jr_redirect_ctrl.sv
// Directed bench for jr_redirect_ctrl: a rule-level model is checked on every
// cycle, and literal expectations from the scenarios pin the model.
module tb_jr_redirect_ctrl;

  logic clk;
  logic rst_n;
  jr_redirect_ctrl_if bus();

  jr_redirect_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pending JR is just a flag; counters are plain ints clamped at 65535.
  bit m_wait = 1'b0, n_wait = 1'b0;
  int m_jr = 0, m_st = 0, n_jr = 0, n_st = 0;

  always @(negedge clk) begin
    bit jr_now, hz;
    int e_sel, e_pw, e_iw, e_if, e_xf, e_busy;
    jr_now = bus.id_valid && bus.id_alu_op == 2'b10 && bus.id_fn == 6'd8;
    hz = bus.id_rs != 0 &&
         ((bus.ex_reg_write && bus.ex_rd == bus.id_rs) ||
          (bus.mem_mem_read && bus.mem_rd == bus.id_rs));
    e_busy = (rst_n && m_wait) ? 1 : 0;
    if (!rst_n) begin
      e_sel = 0; e_pw = 0; e_iw = 0; e_if = 1; e_xf = 1;
      n_wait = 0; n_jr = 0; n_st = 0;
    end else begin
      e_sel = 0; e_pw = 1; e_iw = 1; e_if = 0; e_xf = 0;
      n_wait = m_wait; n_jr = m_jr; n_st = m_st;
      if (bus.ex_branch_taken) begin
        e_sel = 1; e_if = 1; e_xf = 1; n_wait = 0;
      end else if (jr_now && hz) begin
        e_pw = 0; e_iw = 0; e_xf = 1; n_wait = 1;
        n_st = (m_st < 65535) ? m_st + 1 : 65535;
      end else if (jr_now) begin
        e_sel = 3; e_if = 1; n_wait = 0;
        n_jr = (m_jr < 65535) ? m_jr + 1 : 65535;
      end else if (!m_wait && bus.id_jump) begin
        e_sel = 2; e_if = 1;
      end else begin
        n_wait = 0;
      end
    end
    chk("m.pc_sel",     int'(bus.pc_sel),         e_sel);
    chk("m.pc_write",   int'(bus.pc_write),       e_pw);
    chk("m.ifid_write", int'(bus.ifid_write),     e_iw);
    chk("m.ifid_flush", int'(bus.ifid_flush),     e_if);
    chk("m.idex_flush", int'(bus.idex_flush),     e_xf);
    chk("m.busy",       int'(bus.busy),           e_busy);
    chk("m.jr_count",   int'(bus.jr_count),       m_jr);
    chk("m.stall_cnt",  int'(bus.jr_stall_count), m_st);
  end

  always @(posedge clk) begin
    m_wait <= n_wait;
    m_jr   <= n_jr;
    m_st   <= n_st;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input bit v, input bit jmp, input logic [4:0] rs,
                     input bit exw, input logic [4:0] exrd,
                     input bit memr, input logic [4:0] memrd, input bit br);
    bus.id_valid        = v;
    bus.id_alu_op       = v ? 2'b10 : 2'b00;
    bus.id_fn           = v ? 6'b001000 : 6'b000000;
    bus.id_jump         = jmp;
    bus.id_rs           = rs;
    bus.ex_reg_write    = exw;
    bus.ex_rd           = exrd;
    bus.mem_mem_read    = memr;
    bus.mem_rd          = memrd;
    bus.ex_branch_taken = br;
  endtask

  task automatic nop();                  drv(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic mid();                  @(negedge clk); #1;           endtask
  task automatic tick();                 @(posedge clk); #1;           endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop();
    mid();
    chk("rst.pc_sel",     int'(bus.pc_sel),     0);
    chk("rst.pc_write",   int'(bus.pc_write),   0);
    chk("rst.ifid_flush", int'(bus.ifid_flush), 1);
    chk("rst.idex_flush", int'(bus.idex_flush), 1);
    chk("rst.busy",       int'(bus.busy),       0);
    tick();
    rst_n = 1'b1;
    chk("rst.jr_count",   int'(bus.jr_count),       0);
    chk("rst.stall_cnt",  int'(bus.jr_stall_count), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    tick();
    do_reset();

    // JR rs=5, nothing in flight: same-cycle redirect.
    drv(1, 0, 5, 0, 0, 0, 0, 0);
    mid();
    chk("jr0.pc_sel", int'(bus.pc_sel), 3);
    chk("jr0.ifid_flush", int'(bus.ifid_flush), 1);
    chk("jr0.idex_flush", int'(bus.idex_flush), 0);
    tick();
    chk("jr0.jr_count", int'(bus.jr_count), 1);
    chk("jr0.stall", int'(bus.jr_stall_count), 0);

    // JR behind an EX ALU writer: one stall cycle.
    do_reset();
    drv(1, 0, 5, 1, 5, 0, 0, 0);
    mid();
    chk("alu.stall_pcw", int'(bus.pc_write), 0);
    chk("alu.stall_ifw", int'(bus.ifid_write), 0);
    chk("alu.stall_xf", int'(bus.idex_flush), 1);
    tick();
    chk("alu.busy", int'(bus.busy), 1);
    drv(1, 0, 5, 0, 0, 0, 0, 0);
    mid();
    chk("alu.pc_sel", int'(bus.pc_sel), 3);
    tick();
    chk("alu.jr_count", int'(bus.jr_count), 1);
    chk("alu.stall", int'(bus.jr_stall_count), 1);
    chk("alu.busy_end", int'(bus.busy), 0);

    // JR rs=8 behind lw $8: stall in EX, stall in MEM, then redirect.
    do_reset();
    drv(1, 0, 8, 1, 8, 0, 0, 0);
    mid();
    chk("lw.s1_pcw", int'(bus.pc_write), 0);
    tick();
    drv(1, 0, 8, 0, 0, 1, 8, 0);
    mid();
    chk("lw.s2_pcw", int'(bus.pc_write), 0);
    chk("lw.s2_busy", int'(bus.busy), 1);
    tick();
    drv(1, 0, 8, 0, 0, 0, 0, 0);
    mid();
    chk("lw.pc_sel", int'(bus.pc_sel), 3);
    tick();
    chk("lw.stall", int'(bus.jr_stall_count), 2);
    chk("lw.jr_count", int'(bus.jr_count), 1);

    // Stalled JR squashed by a taken branch.
    do_reset();
    drv(1, 0, 5, 1, 5, 0, 0, 0);
    tick();
    drv(1, 0, 5, 0, 0, 1, 5, 1);
    mid();
    chk("brw.pc_sel", int'(bus.pc_sel), 1);
    chk("brw.ifid_flush", int'(bus.ifid_flush), 1);
    chk("brw.idex_flush", int'(bus.idex_flush), 1);
    tick();
    chk("brw.busy", int'(bus.busy), 0);
    chk("brw.jr_count", int'(bus.jr_count), 0);

    // Branch and JR together in IDLE: branch wins, nothing counted.
    drv(1, 0, 5, 0, 0, 0, 0, 1);
    mid();
    chk("brj.pc_sel", int'(bus.pc_sel), 1);
    tick();
    chk("brj.jr_count", int'(bus.jr_count), 0);
    chk("brj.stall", int'(bus.jr_stall_count), 1);

    // J/JAL.
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    mid();
    chk("j.pc_sel", int'(bus.pc_sel), 2);
    chk("j.ifid_flush", int'(bus.ifid_flush), 1);
    tick();

    // JR disappears while waiting: plain fetch, back to IDLE.
    drv(1, 0, 5, 1, 5, 0, 0, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    mid();
    chk("def.pc_sel", int'(bus.pc_sel), 0);
    chk("def.pc_write", int'(bus.pc_write), 1);
    tick();
    chk("def.busy", int'(bus.busy), 0);
    nop();

    // rs=0 never hazards, even with an EX write to $0.
    do_reset();
    drv(1, 0, 0, 1, 0, 0, 0, 0);
    mid();
    chk("r0.pc_sel", int'(bus.pc_sel), 3);
    chk("r0.pc_write", int'(bus.pc_write), 1);
    tick();
    chk("r0.jr_count", int'(bus.jr_count), 1);

    // Reset while waiting on rs.
    do_reset();
    drv(1, 0, 5, 1, 5, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    mid();
    chk("rw.pc_sel", int'(bus.pc_sel), 0);
    chk("rw.pc_write", int'(bus.pc_write), 0);
    chk("rw.ifid_write", int'(bus.ifid_write), 0);
    chk("rw.idex_flush", int'(bus.idex_flush), 1);
    chk("rw.busy", int'(bus.busy), 0);
    tick();
    rst_n = 1'b1;
    nop();
    mid();
    chk("rw.busy_after", int'(bus.busy), 0);
    chk("rw.pc_write_after", int'(bus.pc_write), 1);
    chk("rw.jr_count", int'(bus.jr_count), 0);
    chk("rw.stall", int'(bus.jr_stall_count), 0);
    tick();

    // Saturation: more than 65535 back-to-back JRs.
    do_reset();
    drv(1, 0, 5, 0, 0, 0, 0, 0);
    repeat (65540) tick();
    chk("sat.jr_count", int'(bus.jr_count), 65535);
    mid();
    chk("sat.pc_sel", int'(bus.pc_sel), 3);
    tick();
    chk("sat.jr_hold", int'(bus.jr_count), 65535);
    nop();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
